// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB register-initialisation sequencer.
// Holds the sequencer state enum, the table marker register codes, the
// timeout counter width, and the {register, value} split of a 16-bit table entry.
package sccb_pkg;

    // Sequencer states; the V* states exist only in builds with read-back verify.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_REQ,
        ST_WAIT_DONE,
        ST_WAIT_LOW,
        ST_DELAY,
        ST_VREQ,
        ST_VWAIT,
        ST_VLOW,
        ST_VCHK,
        ST_FINISH,
        ST_FAULT
    } sccb_state_e;

    // Register codes that mark special table entries.
    localparam logic [7:0] SCCB_END   = 8'hFF;
    localparam logic [7:0] SCCB_DELAY = 8'hF0;

    // Width of the per-transaction timeout counter.
    localparam int unsigned TMO_W = 22;

    // One ROM word: [15:8] register, [7:0] value.
    typedef struct packed {
        logic [7:0] regaddr;
        logic [7:0] value;
    } tbl_entry_t;

endpackage

// File: rtl/sccb_txn_handshake.sv
// sccb_txn_handshake: event detector and timeout counter for one SCCB transaction.
// The sequencer reports which phase it is in (request or waiting for done);
// this block returns the events that move it on.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   tmo_clear     - restart the timeout count (entering a request phase)
//   in_req        - a request is being held towards the master
//   in_wait       - waiting for the rising edge of done
//   request_ack   - master acknowledge (level)
//   done          - master completion (level)
//   ack_c         - acknowledge seen while requesting
//   done_rise_c   - rising edge of done while waiting
//   done_low_c    - done is low
//   timeout_c     - the transaction has used its whole cycle budget
module sccb_txn_handshake
    import sccb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic tmo_clear,
    input  logic in_req,
    input  logic in_wait,
    input  logic request_ack,
    input  logic done,
    output logic ack_c,
    output logic done_rise_c,
    output logic done_low_c,
    output logic timeout_c
);

    logic             done_q, done_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             active_c;

    assign active_c = in_req | in_wait;

    // Registered copy of done for edge detection; budget counter.
    always_comb begin
        done_d = done;
        tmo_d  = tmo_q;
        if (tmo_clear) begin
            tmo_d = '0;
        end else if (active_c) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            tmo_q  <= '0;
        end else begin
            done_q <= done_d;
            tmo_q  <= tmo_d;
        end
    end

    // A done already high when waiting starts produces no edge.
    assign ack_c       = in_req & request_ack;
    assign done_rise_c = in_wait & done & ~done_q;
    assign done_low_c  = ~done;
    // Fires on the cycle whose increment would reach TIMEOUT.
    assign timeout_c   = active_c & (tmo_q == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: camera register-initialisation sequencer above the SCCB master.
// Walks a synchronous table ROM of {register, value} entries, writes each
// through the SCCB master, honours end (FF) and delay (F0) markers, and
// reports completion or fault to the capture controller.
// Optional macro: SCCB_INIT_VERIFY_EN - read each register back after writing
// it and fault on mismatch; when undefined read_request/read_addr are tied 0.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start                     - pulse, begins from entry 0 (ignored while busy)
//   busy, init_done, error    - status to the capture controller
//   err_index                 - table index of the faulting entry
//   tbl_addr, tbl_data        - table ROM port, data valid 1 clk after address
//   write_request/addr/data   - write transaction to the SCCB master
//   read_request/addr/data    - read-back transaction to the SCCB master
//   request_ack, done         - SCCB master handshake levels
module sccb_init_seq
    import sccb_pkg::*;
#(
    parameter int unsigned TBL_AW     = 8,
    parameter int unsigned DELAY_UNIT = 50000,
    parameter int unsigned TIMEOUT    = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              init_done,
    output logic              error,
    output logic [TBL_AW-1:0] err_index,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              write_request,
    output logic [7:0]        write_addr,
    output logic [7:0]        write_data,
    output logic              read_request,
    output logic [7:0]        read_addr,
    input  logic [7:0]        read_data,
    input  logic              request_ack,
    input  logic              done
);

    localparam int unsigned       DLY_W    = $clog2(255 * DELAY_UNIT + 1);
    localparam logic [TBL_AW-1:0] IDX_LAST = {TBL_AW{1'b1}};

    sccb_state_e       state_q, state_d;
    logic [TBL_AW-1:0] index_q, index_d;
    logic [TBL_AW-1:0] err_index_q, err_index_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [7:0]        write_addr_q, write_addr_d;
    logic [7:0]        write_data_q, write_data_d;
    logic              write_request_q, write_request_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;
    logic              error_q, error_d;
`ifdef SCCB_INIT_VERIFY_EN
    logic              read_request_q, read_request_d;
    logic [7:0]        read_addr_q, read_addr_d;
`endif

    tbl_entry_t entry_c;
    logic       in_req_c, in_wait_c, tmo_clear_c, last_c;
    logic       ack_c, done_rise_c, done_low_c, timeout_c;

    assign entry_c = tbl_data;
    assign last_c  = (index_q == IDX_LAST);

    // One handshake engine shared by the write and read-back phases.
`ifdef SCCB_INIT_VERIFY_EN
    assign in_req_c  = (state_q == ST_REQ) || (state_q == ST_VREQ);
    assign in_wait_c = (state_q == ST_WAIT_DONE) || (state_q == ST_VWAIT);
`else
    assign in_req_c  = (state_q == ST_REQ);
    assign in_wait_c = (state_q == ST_WAIT_DONE);
`endif

    sccb_txn_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk         (clk),
        .rst         (rst),
        .tmo_clear   (tmo_clear_c),
        .in_req      (in_req_c),
        .in_wait     (in_wait_c),
        .request_ack (request_ack),
        .done        (done),
        .ack_c       (ack_c),
        .done_rise_c (done_rise_c),
        .done_low_c  (done_low_c),
        .timeout_c   (timeout_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        err_index_d    = err_index_q;
        dly_d          = dly_q;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        init_done_d    = init_done_q;
        error_d        = error_q;
`ifdef SCCB_INIT_VERIFY_EN
        read_addr_d    = read_addr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d     = '0;
                    init_done_d = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (entry_c.regaddr == SCCB_END) begin
                    state_d = ST_FINISH;
                end else if (entry_c.regaddr == SCCB_DELAY) begin
                    if (entry_c.value == 8'd0) begin
                        if (last_c) begin
                            state_d = ST_FAULT;
                        end else begin
                            index_d = index_q + TBL_AW'(1);
                            state_d = ST_FETCH;
                        end
                    end else begin
                        dly_d   = DLY_W'(entry_c.value) * DLY_W'(DELAY_UNIT);
                        state_d = ST_DELAY;
                    end
                end else begin
                    write_addr_d = entry_c.regaddr;
                    write_data_d = entry_c.value;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (timeout_c) begin
                    state_d = ST_FAULT;
                end else if (ack_c) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (timeout_c) begin
                    state_d = ST_FAULT;
                end else if (done_rise_c) begin
                    state_d = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (done_low_c) begin
`ifdef SCCB_INIT_VERIFY_EN
                    // Index advances only after the read-back matches, so a
                    // mismatch reports the entry that was just written.
                    read_addr_d = write_addr_q;
                    state_d     = ST_VREQ;
`else
                    if (last_c) begin
                        state_d = ST_FAULT;
                    end else begin
                        index_d = index_q + TBL_AW'(1);
                        state_d = ST_FETCH;
                    end
`endif
                end
            end
            ST_DELAY: begin
                if (dly_q == '0) begin
                    if (last_c) begin
                        state_d = ST_FAULT;
                    end else begin
                        index_d = index_q + TBL_AW'(1);
                        state_d = ST_FETCH;
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
`ifdef SCCB_INIT_VERIFY_EN
            ST_VREQ: begin
                if (timeout_c) begin
                    state_d = ST_FAULT;
                end else if (ack_c) begin
                    state_d = ST_VWAIT;
                end
            end
            ST_VWAIT: begin
                if (timeout_c) begin
                    state_d = ST_FAULT;
                end else if (done_rise_c) begin
                    state_d = ST_VLOW;
                end
            end
            ST_VLOW: begin
                if (done_low_c) begin
                    state_d = ST_VCHK;
                end
            end
            ST_VCHK: begin
                if (read_data != write_data_q) begin
                    state_d = ST_FAULT;
                end else if (last_c) begin
                    state_d = ST_FAULT;
                end else begin
                    index_d = index_q + TBL_AW'(1);
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FINISH: begin
                init_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_FAULT: begin
                error_d     = 1'b1;
                err_index_d = index_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests and busy are registered images of the state being entered,
        // so leaving a request state for any reason drops the request.
        write_request_d = (state_d == ST_REQ);
        busy_d          = (state_d != ST_IDLE) && (state_d != ST_FINISH) &&
                          (state_d != ST_FAULT);
`ifdef SCCB_INIT_VERIFY_EN
        read_request_d  = (state_d == ST_VREQ);
        tmo_clear_c     = ((state_d == ST_REQ) && (state_q != ST_REQ)) ||
                          ((state_d == ST_VREQ) && (state_q != ST_VREQ));
`else
        tmo_clear_c     = (state_d == ST_REQ) && (state_q != ST_REQ);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            index_q         <= '0;
            err_index_q     <= '0;
            dly_q           <= '0;
            write_addr_q    <= '0;
            write_data_q    <= '0;
            write_request_q <= 1'b0;
            busy_q          <= 1'b0;
            init_done_q     <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            index_q         <= index_d;
            err_index_q     <= err_index_d;
            dly_q           <= dly_d;
            write_addr_q    <= write_addr_d;
            write_data_q    <= write_data_d;
            write_request_q <= write_request_d;
            busy_q          <= busy_d;
            init_done_q     <= init_done_d;
            error_q         <= error_d;
        end
    end

`ifdef SCCB_INIT_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            read_request_q <= 1'b0;
            read_addr_q    <= '0;
        end else begin
            read_request_q <= read_request_d;
            read_addr_q    <= read_addr_d;
        end
    end

    assign read_request = read_request_q;
    assign read_addr    = read_addr_q;
`else
    logic unused_c;
    assign unused_c     = ^read_data;
    assign read_request = 1'b0;
    assign read_addr    = 8'h00;
`endif

    // The table index doubles as the ROM address register.
    assign tbl_addr      = index_q;
    assign busy          = busy_q;
    assign init_done     = init_done_q;
    assign error         = error_q;
    assign err_index     = err_index_q;
    assign write_request = write_request_q;
    assign write_addr    = write_addr_q;
    assign write_data    = write_data_q;

endmodule
